// File: rtl/seq_alu_pkg.sv
// -----------------------------------------------------------------------------
// seq_alu_pkg
// Shared definitions for the sequential ALU: opcode encodings, FSM state
// encoding and small opcode-classification helpers.
//
// Build option: SEQ_ALU_DIVIDE_EN enables opcode 10 (unsigned divide). Without
// it, opcode 10 is treated like any other illegal opcode.
// -----------------------------------------------------------------------------
package seq_alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_ROR = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;
  localparam logic [3:0] OP_DIV = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Operations that go through the iterative unit.
  function automatic logic is_multicycle(input logic [3:0] op);
`ifdef SEQ_ALU_DIVIDE_EN
    return (op == OP_MUL) || (op == OP_DIV);
`else
    return (op == OP_MUL);
`endif
  endfunction

  // Legal opcodes are the contiguous range starting at OP_ADD.
  function automatic logic is_legal(input logic [3:0] op);
`ifdef SEQ_ALU_DIVIDE_EN
    return (op <= OP_DIV);
`else
    return (op < OP_DIV);
`endif
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// -----------------------------------------------------------------------------
// seq_alu_if
// Request/response bundle of the sequential ALU.
//   Request  : in_valid, in_ready, opcode, op_a, op_b, shift
//   Response : out_valid, out_ready, result, negative, zero, carry, overflow
// master = requester (register-file read side / testbench)
// slave  = the ALU
// -----------------------------------------------------------------------------
interface seq_alu_if #(
  parameter int WIDTH   = 32,
  parameter int SHIFT_W = $clog2(WIDTH)
);

  logic               in_valid;
  logic               in_ready;
  logic [3:0]         opcode;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [SHIFT_W-1:0] shift;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic               negative;
  logic               zero;
  logic               carry;
  logic               overflow;

  modport master (
    output in_valid, opcode, op_a, op_b, shift, out_ready,
    input  in_ready, out_valid, result, negative, zero, carry, overflow
  );

  modport slave (
    input  in_valid, opcode, op_a, op_b, shift, out_ready,
    output in_ready, out_valid, result, negative, zero, carry, overflow
  );

endinterface

// File: rtl/seq_alu_iter.sv
// -----------------------------------------------------------------------------
// seq_alu_iter
// Iterative unit of the sequential ALU: WIDTH-step shift-add multiplier and,
// with SEQ_ALU_DIVIDE_EN defined, a WIDTH-step unsigned restoring divider.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             load operands and begin iterating (one-cycle pulse)
//   div_sel           (SEQ_ALU_DIVIDE_EN only) 1 = divide, 0 = multiply
//   a, b              operands (multiplicand/multiplier or dividend/divisor)
//   done              high during the final iteration step
//   result            low product word or quotient (valid while done)
//   carry, overflow   product upper word non-zero / remainder non-zero
//
// done and the outputs are taken from the final step's next-state values, so
// the parent can capture the answer on the same edge the last step completes.
// -----------------------------------------------------------------------------
module seq_alu_iter #(
  parameter int WIDTH   = 32,
  parameter int SHIFT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SEQ_ALU_DIVIDE_EN
  input  logic             div_sel,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  localparam logic [SHIFT_W-1:0] LAST_CNT = SHIFT_W'(WIDTH - 1);

  logic               busy_q, busy_d;
  logic [SHIFT_W-1:0] cnt_q, cnt_d;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

`ifdef SEQ_ALU_DIVIDE_EN
  logic               div_q, div_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;
`endif

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`ifdef SEQ_ALU_DIVIDE_EN
    div_d    = div_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    dvsr_d   = dvsr_q;
    rem_sh   = {rem_q, quot_q[WIDTH-1]};
    trial    = rem_sh - {1'b0, dvsr_q};
`endif

    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
`ifdef SEQ_ALU_DIVIDE_EN
      div_d    = div_sel;
      rem_d    = '0;
      quot_d   = a;
      dvsr_d   = b;
`endif
    end else if (busy_q) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_CNT) begin
        busy_d = 1'b0;
      end
      // One partial product per step: add the shifted multiplicand when the
      // current multiplier LSB is set.
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
`ifdef SEQ_ALU_DIVIDE_EN
      // Restoring step: shift the next dividend bit into the remainder and
      // keep the subtraction only if it did not borrow.
      if (!trial[WIDTH]) begin
        rem_d  = trial[WIDTH-1:0];
        quot_d = {quot_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d  = rem_sh[WIDTH-1:0];
        quot_d = {quot_q[WIDTH-2:0], 1'b0};
      end
`endif
    end
  end

  assign done = busy_q && (cnt_q == LAST_CNT);

`ifdef SEQ_ALU_DIVIDE_EN
  assign result   = div_q ? quot_d : acc_d[WIDTH-1:0];
  assign carry    = div_q ? (|rem_d) : (|acc_d[2*WIDTH-1:WIDTH]);
  assign overflow = div_q ? 1'b0 : (|acc_d[2*WIDTH-1:WIDTH]);
`else
  assign result   = acc_d[WIDTH-1:0];
  assign carry    = |acc_d[2*WIDTH-1:WIDTH];
  assign overflow = |acc_d[2*WIDTH-1:WIDTH];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Datapath registers carry no reset: they are always reloaded by start.
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
`ifdef SEQ_ALU_DIVIDE_EN
    div_q    <= div_d;
    rem_q    <= rem_d;
    quot_q   <= quot_d;
    dvsr_q   <= dvsr_d;
`endif
  end

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Handshaked sequential ALU. One operation is accepted per transaction on the
// request channel; result and flags are returned registered on the response
// channel and held until the consumer takes them.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (aborts any operation in flight)
//   bus    seq_alu_if.slave: in_valid/in_ready, opcode, op_a, op_b, shift,
//          out_valid/out_ready, result, negative, zero, carry, overflow
//
// Logic, add/sub and shift ops finish in one cycle; MUL iterates through
// seq_alu_iter for WIDTH cycles. Build option SEQ_ALU_DIVIDE_EN adds opcode 10
// (unsigned divide, also iterative; divide by zero answers in one cycle).
// -----------------------------------------------------------------------------
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHIFT_W = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst_n,
  seq_alu_if.slave bus
);

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             negative_q, negative_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;

  logic             accept;
  logic             div_zero;
  logic             iter_start;
  logic             iter_done;
  logic [WIDTH-1:0] iter_result;
  logic             iter_carry;
  logic             iter_overflow;

  logic [WIDTH:0]     add_w;
  logic [WIDTH:0]     sub_w;
  logic               add_ovf;
  logic               sub_ovf;
  logic [SHIFT_W-1:0] shl_idx;
  logic [WIDTH-1:0]   ror_w;
  logic [WIDTH-1:0]   sc_result;
  logic               sc_carry;
  logic               sc_overflow;

  logic             load_en;
  logic [WIDTH-1:0] load_result;
  logic             load_carry;
  logic             load_overflow;

  // in_ready is registered so it reads 0 while reset is held.
  assign accept = in_ready_q && bus.in_valid;

`ifdef SEQ_ALU_DIVIDE_EN
  assign div_zero = (bus.opcode == OP_DIV) && (bus.op_b == '0);
`else
  assign div_zero = 1'b0;
`endif

  assign iter_start = accept && is_multicycle(bus.opcode) && !div_zero;

  seq_alu_iter #(
    .WIDTH   (WIDTH),
    .SHIFT_W (SHIFT_W)
  ) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (iter_start),
`ifdef SEQ_ALU_DIVIDE_EN
    .div_sel  (bus.opcode == OP_DIV),
`endif
    .a        (bus.op_a),
    .b        (bus.op_b),
    .done     (iter_done),
    .result   (iter_result),
    .carry    (iter_carry),
    .overflow (iter_overflow)
  );

  // Single-cycle datapath, evaluated on the live request operands.
  assign add_w   = {1'b0, bus.op_a} + {1'b0, bus.op_b};
  assign sub_w   = {1'b0, bus.op_a} - {1'b0, bus.op_b};
  assign add_ovf = (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1]) &&
                   (add_w[WIDTH-1] != bus.op_a[WIDTH-1]);
  assign sub_ovf = (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1]) &&
                   (sub_w[WIDTH-1] != bus.op_a[WIDTH-1]);
  // WIDTH - shift, modulo WIDTH (WIDTH is a power of two). For SHL this is
  // the index of the last bit shifted out; for ROR it is the left-shift
  // amount, which collapses to 0 when shift == 0 so the rotate passes a.
  assign shl_idx = ~bus.shift + 1'b1;
  assign ror_w   = (bus.op_a >> bus.shift) | (bus.op_a << shl_idx);

  always_comb begin
    sc_result   = '0;
    sc_carry    = 1'b0;
    sc_overflow = 1'b0;
    if (is_legal(bus.opcode)) begin
      case (bus.opcode)
        OP_ADD: begin
          sc_result   = add_w[WIDTH-1:0];
          sc_carry    = add_w[WIDTH];
          sc_overflow = add_ovf;
        end
        OP_SUB, OP_CMP: begin
          sc_result   = sub_w[WIDTH-1:0];
          sc_carry    = sub_w[WIDTH];
          sc_overflow = sub_ovf;
        end
        OP_OR:  sc_result = bus.op_a | bus.op_b;
        OP_AND: sc_result = bus.op_a & bus.op_b;
        OP_XOR: sc_result = bus.op_a ^ bus.op_b;
        OP_SHR: begin
          sc_result = bus.op_a >> bus.shift;
          sc_carry  = (bus.shift != '0) ? bus.op_a[bus.shift - 1'b1] : 1'b0;
        end
        OP_SHL: begin
          sc_result = bus.op_a << bus.shift;
          sc_carry  = (bus.shift != '0) ? bus.op_a[shl_idx] : 1'b0;
        end
        OP_ROR: begin
          sc_result = ror_w;
          sc_carry  = (bus.shift != '0) && ror_w[WIDTH-1];
        end
`ifdef SEQ_ALU_DIVIDE_EN
        // Only reached for a zero divisor; other divides iterate.
        OP_DIV: begin
          sc_result   = '1;
          sc_overflow = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    out_valid_d   = out_valid_q;
    result_d      = result_q;
    negative_d    = negative_q;
    zero_d        = zero_q;
    carry_d       = carry_q;
    overflow_d    = overflow_q;
    load_en       = 1'b0;
    load_result   = '0;
    load_carry    = 1'b0;
    load_overflow = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (iter_start) begin
            state_d = S_BUSY;
          end else begin
            state_d       = S_DONE;
            load_en       = 1'b1;
            load_result   = sc_result;
            load_carry    = sc_carry;
            load_overflow = sc_overflow;
          end
        end
      end
      S_BUSY: begin
        if (iter_done) begin
          state_d       = S_DONE;
          load_en       = 1'b1;
          load_result   = iter_result;
          load_carry    = iter_carry;
          load_overflow = iter_overflow;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every completion rewrites all flags so none are left from a prior op.
    if (load_en) begin
      out_valid_d = 1'b1;
      result_d    = load_result;
      negative_d  = load_result[WIDTH-1];
      zero_d      = (load_result == '0);
      carry_d     = load_carry;
      overflow_d  = load_overflow;
    end

    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      negative_q  <= 1'b0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      negative_q  <= negative_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.negative  = negative_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
// Directed bench for seq_alu (WIDTH=32). Stimulus pushes hand-computed
// expectations into a scoreboard queue; a monitor pops and compares each
// result accepted on the response channel. Latency, back-pressure and reset
// behaviour are checked inline by the stimulus process.
// -----------------------------------------------------------------------------
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W  = 32;
  localparam int SW = $clog2(W);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    string        name;
    logic [W-1:0] r;
    logic         n;
    logic         z;
    logic         c;
    logic         v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic chki(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input string name, input logic [W-1:0] r,
                      input logic n, input logic z, input logic c, input logic v);
    exp_t e;
    e.name = name; e.r = r; e.n = n; e.z = z; e.c = c; e.v = v;
    sb.push_back(e);
  endtask

  // Present one request and hold it until the accept edge; returns 1 time
  // unit after that edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [SW-1:0] sh);
    int t = 0;
    while (!bus.in_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (!bus.in_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL issue_timeout: in_ready got 0, required 1 within 200 cycles");
    end
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.shift    = sh;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Count cycles from the accept edge until out_valid; optionally require
  // in_ready low while waiting.
  task automatic wait_out(input string name, input int lat, input bit busy_chk);
    int cyc = 1;
    int rdy_hi = 0;
    while (!bus.out_valid && cyc < 200) begin
      if (bus.in_ready) rdy_hi++;
      @(posedge clk); #1; cyc++;
    end
    chki({name, "_latency"}, cyc, lat);
    if (busy_chk) chki({name, "_in_ready_high_cycles_busy"}, rdy_hi, 0);
  endtask

  // Monitor: compare each accepted response against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_output: got result %h, required no output", bus.result);
        end else begin
          e = sb.pop_front();
          chk ({e.name, "_result"},   bus.result,   e.r);
          chk1({e.name, "_negative"}, bus.negative, e.n);
          chk1({e.name, "_zero"},     bus.zero,     e.z);
          chk1({e.name, "_carry"},    bus.carry,    e.c);
          chk1({e.name, "_overflow"}, bus.overflow, e.v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.opcode    = '0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.shift     = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    chk1("rst_in_ready",  bus.in_ready,  1'b0);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk ("rst_result",    bus.result,    '0);
    chk1("rst_negative",  bus.negative,  1'b0);
    chk1("rst_zero",      bus.zero,      1'b0);
    chk1("rst_carry",     bus.carry,     1'b0);
    chk1("rst_overflow",  bus.overflow,  1'b0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("post_rst_in_ready", bus.in_ready, 1'b1);

    // ADD wrap to zero
    push("add_wrap", 32'h0000_0000, 0, 1, 1, 0);
    issue(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    wait_out("add_wrap", 1, 0);

    // SUB / CMP with borrow and signed overflow
    push("sub", 32'h8000_0000, 1, 0, 1, 1);
    issue(OP_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0);
    wait_out("sub", 1, 0);
    push("cmp", 32'h8000_0000, 1, 0, 1, 1);
    issue(OP_CMP, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0);
    wait_out("cmp", 1, 0);

    // MUL with upper-word overflow, then a fitting product
    push("mul_ovf", 32'h0000_0000, 0, 1, 1, 1);
    issue(OP_MUL, 32'h0001_0000, 32'h0001_0000, 0);
    wait_out("mul_ovf", 33, 1);
    push("mul_fit", 32'h0002_FFFD, 0, 0, 0, 0);
    issue(OP_MUL, 32'h0000_FFFF, 32'h0000_0003, 0);
    wait_out("mul_fit", 33, 1);

    // Shifts and rotate
    push("shl", 32'h0000_0002, 0, 0, 1, 0);
    issue(OP_SHL, 32'h8000_0001, '0, 5'd1);
    wait_out("shl", 1, 0);
    push("ror", 32'h8000_0000, 1, 0, 1, 0);
    issue(OP_ROR, 32'h0000_0001, '0, 5'd1);
    wait_out("ror", 1, 0);
    push("shr", 32'h0000_0001, 0, 0, 1, 0);
    issue(OP_SHR, 32'h0000_0003, '0, 5'd1);
    wait_out("shr", 1, 0);
    push("shr_zero_amt", 32'h8000_0000, 1, 0, 0, 0);
    issue(OP_SHR, 32'h8000_0000, '0, 5'd0);
    wait_out("shr_zero_amt", 1, 0);

    // Logic ops (carry from the previous op must not linger)
    push("ror_again", 32'h8000_0000, 1, 0, 1, 0);
    issue(OP_ROR, 32'h0000_0001, '0, 5'd1);
    wait_out("ror_again", 1, 0);
    push("or", 32'hF0F0_0F0F, 1, 0, 0, 0);
    issue(OP_OR, 32'hF0F0_0000, 32'h0000_0F0F, 0);
    wait_out("or", 1, 0);
    push("and", 32'h0F00_0F00, 0, 0, 0, 0);
    issue(OP_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 0);
    wait_out("and", 1, 0);

    // Illegal opcodes
    push("illegal15", 32'h0000_0000, 0, 1, 0, 0);
    issue(4'd15, 32'h0000_0005, 32'h0000_0006, 0);
    wait_out("illegal15", 1, 0);
`ifdef SEQ_ALU_DIVIDE_EN
    push("op10_div", 32'h0000_000E, 0, 0, 1, 0);
    issue(4'd10, 32'd100, 32'd7, 0);
    wait_out("op10_div", 33, 1);
    push("div_zero", 32'hFFFF_FFFF, 1, 0, 0, 1);
    issue(4'd10, 32'd100, 32'd0, 0);
    wait_out("div_zero", 1, 0);
`else
    push("op10_illegal", 32'h0000_0000, 0, 1, 0, 0);
    issue(4'd10, 32'd100, 32'd7, 0);
    wait_out("op10_illegal", 1, 0);
`endif

    // Back-pressure: XOR result held for 5 cycles, new requests ignored
    push("xor_bp", 32'h5A5A_5A5A, 0, 0, 0, 0);
    issue(OP_XOR, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 0);
    bus.out_ready = 1'b0;
    wait_out("xor_bp", 1, 0);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.opcode   = OP_ADD;
      bus.op_a     = 32'h0000_0001;
      bus.op_b     = 32'h0000_0001;
      chk1("bp_out_valid", bus.out_valid, 1'b1);
      chk1("bp_in_ready",  bus.in_ready,  1'b0);
      chk ("bp_result",    bus.result,    32'h5A5A_5A5A);
      chk1("bp_negative",  bus.negative,  1'b0);
      chk1("bp_zero",      bus.zero,      1'b0);
      chk1("bp_carry",     bus.carry,     1'b0);
      chk1("bp_overflow",  bus.overflow,  1'b0);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk1("bp_release_in_ready",  bus.in_ready,  1'b1);
    chk1("bp_release_out_valid", bus.out_valid, 1'b0);

    // ADD signed overflow, leaves a non-zero result behind
    push("add_ovf", 32'h8000_0000, 1, 0, 0, 1);
    issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    wait_out("add_ovf", 1, 0);

    // Reset during BUSY cycle 10: MUL is discarded
    issue(OP_MUL, 32'h0000_0003, 32'h0000_0005, 0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk1("abort_out_valid", bus.out_valid, 1'b0);
    chk1("abort_in_ready",  bus.in_ready,  1'b0);
    chk ("abort_result",    bus.result,    '0);
    chk1("abort_negative",  bus.negative,  1'b0);
    chk1("abort_zero",      bus.zero,      1'b0);
    chk1("abort_carry",     bus.carry,     1'b0);
    chk1("abort_overflow",  bus.overflow,  1'b0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    push("add_after_rst", 32'h0000_0005, 0, 0, 0, 0);
    issue(OP_ADD, 32'd2, 32'd3, 0);
    wait_out("add_after_rst", 1, 0);

    repeat (40) begin
      @(posedge clk); #1;
    end
    chki("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
